spi_reg_slave: RTL and testbench
================================

Name: spi_reg_slave

Overview:
- Next-generation SPI register slave behind the chip's SPI pins.
- Generalises the current fixed 4+4 byte register wrapper in four ways:
  - parametrised config/status register counts;
  - parametrised data word width;
  - all four SPI modes, latched per frame;
  - burst read/write with address auto-increment.
- Sits after the input synchronizers and drives MISO plus a flat config-register bus to the core logic.
- Runs entirely on the system clock and oversamples the synchronized SPI clock.

Parameters:
- NUM_CFG, 8, number of read/write config registers (1..64).
- NUM_STATUS, 8, number of read-only status registers (1..64).
- REG_WIDTH, 8, bits per register and per SPI data word (8, 16 or 32).
- CFG_RESET, 0, reset value of every config register (REG_WIDTH bits).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ena  in  1  clock enable; when low, all state holds.
- mode  in  2  {cpol,cpha}, already synchronized.
- spi_cs_n  in  1  synchronized chip select, active low.
- spi_clk  in  1  synchronized SPI clock.
- spi_mosi  in  1  synchronized MOSI.
- spi_miso  out  1  registered MISO.
- config_regs  out  NUM_CFG*REG_WIDTH  flat config bus; reg i at [i*REG_WIDTH +: REG_WIDTH].
- status_regs  in  NUM_STATUS*REG_WIDTH  flat status bus, same packing.
- cfg_wr_stb  out  NUM_CFG  one-clk pulse per config register written.
- busy  out  1  high while a frame is active (state != IDLE).

Behaviour:
- Reset (async, rst=1), all registers cleared:
  - spi_miso=0, busy=0, cfg_wr_stb=0, config_regs=CFG_RESET in every slot;
  - state=IDLE, bit counter=0, address=0.
- Edge detect:
  - spi_clk is registered once; rise = spi_clk & ~spi_clk_q, fall = ~spi_clk & spi_clk_q.
  - lead = rise if cpol=0, else fall; trail = the opposite edge.
  - sample edge = lead if cpha=0, else trail; shift edge = the other one.
- Mode latching: mode is captured on the clk where spi_cs_n is first seen low. Mode changes mid-frame are ignored.
- Frame format, MSB first:
  - command byte: bit7 = 1 write / 0 read; bits[6:0] = start address.
  - then any number of REG_WIDTH-bit data words.
- Address map:
  - 0..NUM_CFG-1 are config registers.
  - NUM_CFG..NUM_CFG+NUM_STATUS-1 are status registers.
  - Higher addresses read as 0; writes to them are ignored.
  - Writes to status addresses are ignored (no strobe).
- Auto-increment:
  - address += 1 after every completed data word.
  - Wraps to 0 after NUM_CFG+NUM_STATUS-1.
  - An out-of-range start address also wraps to 0 at that point.
- FSM states IDLE, CMD, WDATA, RDATA:
  - IDLE -> CMD when cs_n is low (counter cleared).
  - CMD -> WDATA or RDATA after the 8th sample edge.
  - WDATA and RDATA loop per word.
  - Any state -> IDLE on the clk cs_n is seen high.
- Bit counter counts sample edges:
  - wraps at 8 in CMD and at REG_WIDTH in data states.
  - rx shifts mosi in on each sample edge.
- Write: on the final sample edge of a data word in WDATA with address < NUM_CFG, the next clk:
  - config_regs[addr] <= received word;
  - cfg_wr_stb[addr] pulses for exactly 1 clk.
- Read prefetch: tx word <= register[addr] (status sampled at that clk). This happens:
  - at CMD completion for a read;
  - at each RDATA word completion, using the incremented address.
- MISO:
  - On each shift edge in RDATA, spi_miso <= tx[REG_WIDTH-1-bit_cnt].
  - This places the MSB after the last command-byte sample for cpha=0, and on the first lead edge for cpha=1.
  - spi_miso is 0 in IDLE, in CMD (cpha=1 case), and throughout WDATA.
- Abort: cs_n rising mid-word discards the partial word. No write, no strobe, address not incremented; the next frame starts clean.
- Simultaneous events: a cs_n rise takes priority over an edge detected in the same clk.
- ena=0: all registers hold. Edges during ena=0 are lost; this is acceptable.

Decomposition:
- Shared package spi_reg_pkg:
  - state enum (IDLE/CMD/WDATA/RDATA);
  - CMD_W=8, ADDR_W=7, write-bit index;
  - function for address wrap.
- Sub-module spi_edge_det: registers spi_clk and decodes sample/shift edges from the latched mode.
- The FSM, shift registers and register file stay in spi_reg_slave.

Test Plan:
- Reset: assert rst mid-frame -> config_regs all CFG_RESET, spi_miso=0, busy=0 asynchronously; the next frame works.
- Mode 0 single write: cmd 0x83, data 0xA5 -> config reg3=0xA5, cfg_wr_stb=0x08 for one clk, other registers unchanged.
- Mode 3 burst read: cmd 0x06, 3 words, status reg0..2={0xCA,0x10,0xAA}, NUM_CFG=6 -> MISO returns 0xCA,0x10,0xAA.
- Wrap and ignore: NUM_CFG=8, NUM_STATUS=8, cmd 0x8F, write 0x11,0x22 -> status write ignored (no strobe), config reg0=0x22.
- Abort: cmd 0x81, then 5 bits of data and cs_n high -> reg1 unchanged, no strobe; a following cmd 0x01 read returns the old value.
- REG_WIDTH=16, modes 1 and 2: write 0xBEEF to reg2, read back -> 0xBEEF; out-of-range read at 0x7F returns 0x0000.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register slave.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA
  } state_t;

  localparam int CMD_W  = 8;
  localparam int ADDR_W = 7;
  localparam int WR_BIT = 7;

  // Next burst address; the last mapped address and anything beyond it wrap to 0.
  function automatic logic [ADDR_W-1:0] addr_wrap(input logic [ADDR_W-1:0] addr,
                                                  input int total);
    if (int'(addr) >= total - 1) return '0;
    return addr + 1'b1;
  endfunction

endpackage

// File: rtl/spi_edge_det.sv
// Registers the synchronized SPI clock and decodes sample/shift edges for the
// frame's latched {cpol,cpha}.
module spi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic spi_clk,
  input  logic cpol,
  input  logic cpha,
  output logic sample_edge,
  output logic shift_edge
);

  logic spi_clk_q;
  logic rise, fall, lead, trail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) spi_clk_q <= 1'b0;
    else if (ena) spi_clk_q <= spi_clk;
  end

  assign rise  = spi_clk & ~spi_clk_q;
  assign fall  = ~spi_clk & spi_clk_q;
  assign lead  = cpol ? fall : rise;
  assign trail = cpol ? rise : fall;

  assign sample_edge = cpha ? trail : lead;
  assign shift_edge  = cpha ? lead : trail;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI register slave: command byte then burst data words with address
// auto-increment, config registers read/write, status registers read-only.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8,
  parameter logic [REG_WIDTH-1:0] CFG_RESET = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ena,
  input  logic [1:0]                      mode,
  input  logic                            spi_cs_n,
  input  logic                            spi_clk,
  input  logic                            spi_mosi,
  output logic                            spi_miso,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic [NUM_CFG-1:0]              cfg_wr_stb,
  output logic                            busy
);

  localparam int TOTAL = NUM_CFG + NUM_STATUS;
  localparam int CNT_W = $clog2(REG_WIDTH);

  state_t                 state, state_n;
  logic [1:0]             mode_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic [ADDR_W-1:0]      addr, addr_nxt, cmd_addr, rd_addr;
  logic [REG_WIDTH-1:0]   rx, rx_next, tx, rd_word;
  logic                   sample_edge, shift_edge;
  logic                   cmd_last, word_last, cmd_wr;

  spi_edge_det u_edge (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .spi_clk     (spi_clk),
    .cpol        (mode_q[1]),
    .cpha        (mode_q[0]),
    .sample_edge (sample_edge),
    .shift_edge  (shift_edge)
  );

  assign rx_next   = {rx[REG_WIDTH-2:0], spi_mosi};
  assign cmd_addr  = rx_next[ADDR_W-1:0];
  assign cmd_wr    = rx_next[WR_BIT];
  assign cmd_last  = (bit_cnt == CNT_W'(CMD_W - 1));
  assign word_last = (bit_cnt == CNT_W'(REG_WIDTH - 1));
  assign addr_nxt  = addr_wrap(addr, TOTAL);
  // Prefetch target: start address at command completion, else the next burst address.
  assign rd_addr   = (state == ST_CMD) ? cmd_addr : addr_nxt;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CFG; i++)
      if (rd_addr == ADDR_W'(i)) rd_word = config_regs[i*REG_WIDTH +: REG_WIDTH];
    for (int j = 0; j < NUM_STATUS; j++)
      if (rd_addr == ADDR_W'(NUM_CFG + j)) rd_word = status_regs[j*REG_WIDTH +: REG_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else if (ena) state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (!spi_cs_n) state_n = ST_CMD;
      ST_CMD:  if (sample_edge && cmd_last) state_n = cmd_wr ? ST_WDATA : ST_RDATA;
      default: state_n = state;
    endcase
    if (spi_cs_n) state_n = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= '0;
      bit_cnt     <= '0;
      addr        <= '0;
      rx          <= '0;
      tx          <= '0;
      spi_miso    <= 1'b0;
      config_regs <= {NUM_CFG{CFG_RESET}};
      cfg_wr_stb  <= '0;
    end else if (ena) begin
      cfg_wr_stb <= '0;
      // Chip select high wins over any edge seen in the same clk; partial words are dropped.
      if (spi_cs_n) begin
        bit_cnt  <= '0;
        spi_miso <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            mode_q   <= mode;
            bit_cnt  <= '0;
            spi_miso <= 1'b0;
          end
          ST_CMD: begin
            spi_miso <= 1'b0;
            if (sample_edge) begin
              rx <= rx_next;
              if (cmd_last) begin
                bit_cnt <= '0;
                addr    <= cmd_addr;
                if (!cmd_wr) tx <= rd_word;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_WDATA: begin
            spi_miso <= 1'b0;
            if (sample_edge) begin
              rx <= rx_next;
              if (word_last) begin
                bit_cnt <= '0;
                addr    <= addr_nxt;
                for (int i = 0; i < NUM_CFG; i++)
                  if (addr == ADDR_W'(i)) begin
                    config_regs[i*REG_WIDTH +: REG_WIDTH] <= rx_next;
                    cfg_wr_stb[i] <= 1'b1;
                  end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_RDATA: begin
            if (shift_edge) begin
              spi_miso <= tx[REG_WIDTH-1];
              tx       <= {tx[REG_WIDTH-2:0], 1'b0};
            end
            if (sample_edge) begin
              rx <= rx_next;
              if (word_last) begin
                bit_cnt <= '0;
                addr    <= addr_nxt;
                tx      <= rd_word;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: three instances cover 8-bit (8/8 and 6/8
// register maps) and 16-bit words across all SPI modes.
module tb_spi_reg_slave;

  localparam int HP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        cs_a = 1'b1, cs_b = 1'b1, cs_c = 1'b1;

  logic        miso_a, miso_b, miso_c;
  logic        busy_a, busy_b, busy_c;
  logic [63:0] cfg_a;
  logic [47:0] cfg_b;
  logic [63:0] cfg_c;
  logic [7:0]  stb_a;
  logic [5:0]  stb_b;
  logic [3:0]  stb_c;
  logic [63:0] status_a = 64'h8877_6655_4433_2211;
  logic [63:0] status_b = 64'h0000_0000_00AA_10CA;
  logic [63:0] status_c = 64'h4444_3333_2222_1111;

  int          checks = 0;
  int          errors = 0;
  int          stb_cnt_a = 0, stb_cnt_c = 0;
  logic [7:0]  stb_last_a = '0;
  logic [3:0]  stb_last_c = '0;
  logic [31:0] tx_w [4];
  logic [31:0] rx_w [4];

  always #5 clk = ~clk;

  spi_reg_slave #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8), .CFG_RESET(8'h00)) u_a (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .spi_cs_n(cs_a), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(miso_a), .config_regs(cfg_a), .status_regs(status_a),
    .cfg_wr_stb(stb_a), .busy(busy_a));

  spi_reg_slave #(.NUM_CFG(6), .NUM_STATUS(8), .REG_WIDTH(8), .CFG_RESET(8'h00)) u_b (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .spi_cs_n(cs_b), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(miso_b), .config_regs(cfg_b), .status_regs(status_b),
    .cfg_wr_stb(stb_b), .busy(busy_b));

  spi_reg_slave #(.NUM_CFG(4), .NUM_STATUS(4), .REG_WIDTH(16), .CFG_RESET(16'h0000)) u_c (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .spi_cs_n(cs_c), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(miso_c), .config_regs(cfg_c), .status_regs(status_c),
    .cfg_wr_stb(stb_c), .busy(busy_c));

  always @(negedge clk) begin
    if (stb_a != 0) begin
      stb_cnt_a  <= stb_cnt_a + 1;
      stb_last_a <= stb_a;
    end
    if (stb_c != 0) begin
      stb_cnt_c  <= stb_cnt_c + 1;
      stb_last_c <= stb_c;
    end
  end

  function automatic logic miso_sel(input int sel);
    case (sel)
      0:       return miso_a;
      1:       return miso_b;
      default: return miso_c;
    endcase
  endfunction

  task automatic set_cs(input int sel, input logic v);
    case (sel)
      0:       cs_a = v;
      1:       cs_b = v;
      default: cs_c = v;
    endcase
  endtask

  task automatic xfer_bit(input int sel, input logic [1:0] md, input logic ob, output logic ib);
    if (!md[0]) begin
      spi_mosi = ob;
      repeat (HP) @(negedge clk);
      ib = miso_sel(sel);
      spi_clk = ~spi_clk;
      repeat (HP) @(negedge clk);
      spi_clk = ~spi_clk;
    end else begin
      spi_clk = ~spi_clk;
      spi_mosi = ob;
      repeat (HP) @(negedge clk);
      ib = miso_sel(sel);
      spi_clk = ~spi_clk;
      repeat (HP) @(negedge clk);
    end
  endtask

  // stop_bits < 0 runs the whole frame; leave_cs keeps chip select low at the end.
  task automatic frame(input int sel, input logic [1:0] md, input logic [7:0] cmd,
                       input int nw, input int w, input int stop_bits, input bit leave_cs);
    int   total;
    logic ob, ib;
    mode     = md;
    spi_clk  = md[1];
    spi_mosi = 1'b0;
    for (int i = 0; i < 4; i++) rx_w[i] = '0;
    repeat (2) @(negedge clk);
    set_cs(sel, 1'b0);
    repeat (4) @(negedge clk);
    total = 8 + nw * w;
    for (int k = 0; k < total; k++) begin
      if (stop_bits >= 0 && k >= stop_bits) break;
      if (k < 8) ob = cmd[7-k];
      else ob = tx_w[(k-8)/w][w-1-((k-8)%w)];
      xfer_bit(sel, md, ob, ib);
      if (k >= 8) rx_w[(k-8)/w][w-1-((k-8)%w)] = ib;
    end
    repeat (4) @(negedge clk);
    if (!leave_cs) begin
      set_cs(sel, 1'b1);
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (cfg_a !== 64'h0) begin errors++; $display("FAIL reset_cfg_a got %h exp %h", cfg_a, 64'h0); end
    checks++; if (cfg_c !== 64'h0) begin errors++; $display("FAIL reset_cfg_c got %h exp %h", cfg_c, 64'h0); end
    checks++; if (miso_a !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    checks++; if (stb_a !== 8'h00) begin errors++; $display("FAIL reset_stb got %h exp 00", stb_a); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mode0_write;
    int c0;
    c0 = stb_cnt_a;
    tx_w[0] = 32'hA5;
    frame(0, 2'b00, 8'h83, 1, 8, -1, 1'b0);
    checks++; if (cfg_a !== 64'h0000_0000_A500_0000) begin errors++; $display("FAIL m0_write_cfg got %h exp %h", cfg_a, 64'h0000_0000_A500_0000); end
    checks++; if (stb_cnt_a - c0 !== 1) begin errors++; $display("FAIL m0_write_stb_cycles got %0d exp 1", stb_cnt_a - c0); end
    checks++; if (stb_last_a !== 8'h08) begin errors++; $display("FAIL m0_write_stb got %h exp 08", stb_last_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL m0_write_busy got %b exp 0", busy_a); end
  endtask

  task automatic test_wrap;
    int c0;
    c0 = stb_cnt_a;
    tx_w[0] = 32'h11;
    tx_w[1] = 32'h22;
    frame(0, 2'b00, 8'h8F, 2, 8, -1, 1'b0);
    checks++; if (cfg_a !== 64'h0000_0000_A500_0022) begin errors++; $display("FAIL wrap_cfg got %h exp %h", cfg_a, 64'h0000_0000_A500_0022); end
    checks++; if (stb_cnt_a - c0 !== 1) begin errors++; $display("FAIL wrap_stb_cycles got %0d exp 1", stb_cnt_a - c0); end
    checks++; if (stb_last_a !== 8'h01) begin errors++; $display("FAIL wrap_stb got %h exp 01", stb_last_a); end
  endtask

  task automatic test_abort;
    int c0;
    tx_w[0] = 32'h3C;
    frame(0, 2'b00, 8'h81, 1, 8, -1, 1'b0);
    checks++; if (cfg_a !== 64'h0000_0000_A500_3C22) begin errors++; $display("FAIL abort_pre_cfg got %h exp %h", cfg_a, 64'h0000_0000_A500_3C22); end
    c0 = stb_cnt_a;
    tx_w[0] = 32'hFF;
    frame(0, 2'b00, 8'h81, 1, 8, 13, 1'b0);
    checks++; if (cfg_a !== 64'h0000_0000_A500_3C22) begin errors++; $display("FAIL abort_cfg got %h exp %h", cfg_a, 64'h0000_0000_A500_3C22); end
    checks++; if (stb_cnt_a - c0 !== 0) begin errors++; $display("FAIL abort_stb_cycles got %0d exp 0", stb_cnt_a - c0); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy_a); end
    frame(0, 2'b00, 8'h01, 1, 8, -1, 1'b0);
    checks++; if (rx_w[0][7:0] !== 8'h3C) begin errors++; $display("FAIL abort_readback got %h exp 3c", rx_w[0][7:0]); end
  endtask

  task automatic test_burst_read_m3;
    frame(1, 2'b11, 8'h06, 3, 8, -1, 1'b0);
    checks++; if (rx_w[0][7:0] !== 8'hCA) begin errors++; $display("FAIL m3_read_w0 got %h exp ca", rx_w[0][7:0]); end
    checks++; if (rx_w[1][7:0] !== 8'h10) begin errors++; $display("FAIL m3_read_w1 got %h exp 10", rx_w[1][7:0]); end
    checks++; if (rx_w[2][7:0] !== 8'hAA) begin errors++; $display("FAIL m3_read_w2 got %h exp aa", rx_w[2][7:0]); end
    checks++; if (miso_b !== 1'b0) begin errors++; $display("FAIL m3_idle_miso got %b exp 0", miso_b); end
    checks++; if (cfg_b !== 48'h0) begin errors++; $display("FAIL m3_cfg_b got %h exp 0", cfg_b); end
  endtask

  task automatic test_w16_modes12;
    int c0;
    c0 = stb_cnt_c;
    tx_w[0] = 32'h1234;
    tx_w[1] = 32'hBEEF;
    frame(2, 2'b01, 8'h81, 2, 16, -1, 1'b0);
    checks++; if (cfg_c !== 64'h0000_BEEF_1234_0000) begin errors++; $display("FAIL w16_cfg got %h exp %h", cfg_c, 64'h0000_BEEF_1234_0000); end
    checks++; if (stb_cnt_c - c0 !== 2) begin errors++; $display("FAIL w16_stb_cycles got %0d exp 2", stb_cnt_c - c0); end
    checks++; if (stb_last_c !== 4'h4) begin errors++; $display("FAIL w16_stb got %h exp 4", stb_last_c); end
    frame(2, 2'b10, 8'h02, 1, 16, -1, 1'b0);
    checks++; if (rx_w[0][15:0] !== 16'hBEEF) begin errors++; $display("FAIL w16_readback got %h exp beef", rx_w[0][15:0]); end
    frame(2, 2'b10, 8'h7F, 3, 16, -1, 1'b0);
    checks++; if (rx_w[0][15:0] !== 16'h0000) begin errors++; $display("FAIL w16_oor got %h exp 0000", rx_w[0][15:0]); end
    checks++; if (rx_w[1][15:0] !== 16'h0000) begin errors++; $display("FAIL w16_wrap_r0 got %h exp 0000", rx_w[1][15:0]); end
    checks++; if (rx_w[2][15:0] !== 16'h1234) begin errors++; $display("FAIL w16_wrap_r1 got %h exp 1234", rx_w[2][15:0]); end
  endtask

  task automatic test_reset_mid_frame;
    int c0;
    frame(0, 2'b00, 8'h03, 1, 8, 8, 1'b1);
    checks++; if (miso_a !== 1'b1) begin errors++; $display("FAIL mid_msb got %b exp 1", miso_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy_a); end
    #3 rst = 1'b1;
    #1;
    checks++; if (miso_a !== 1'b0) begin errors++; $display("FAIL rst_miso got %b exp 0", miso_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_a); end
    checks++; if (cfg_a !== 64'h0) begin errors++; $display("FAIL rst_cfg_a got %h exp 0", cfg_a); end
    checks++; if (cfg_c !== 64'h0) begin errors++; $display("FAIL rst_cfg_c got %h exp 0", cfg_c); end
    @(negedge clk);
    rst = 1'b0;
    cs_a = 1'b1;
    repeat (4) @(negedge clk);
    c0 = stb_cnt_a;
    tx_w[0] = 32'h5A;
    frame(0, 2'b00, 8'h84, 1, 8, -1, 1'b0);
    checks++; if (cfg_a !== 64'h0000_005A_0000_0000) begin errors++; $display("FAIL post_rst_cfg got %h exp %h", cfg_a, 64'h0000_005A_0000_0000); end
    checks++; if (stb_cnt_a - c0 !== 1) begin errors++; $display("FAIL post_rst_stb_cycles got %0d exp 1", stb_cnt_a - c0); end
    checks++; if (stb_last_a !== 8'h10) begin errors++; $display("FAIL post_rst_stb got %h exp 10", stb_last_a); end
  endtask

  initial begin
    test_reset;
    test_mode0_write;
    test_wrap;
    test_abort;
    test_burst_read_m3;
    test_w16_modes12;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
